// File: rtl/can_rx_accept_fifo_if.sv
// Frame bus between the CAN receive decoder, the acceptance FIFO and the
// downstream consumer.
//
// Handshake rules:
//   - Input side is a strobe, not a handshake. in_valid is high for exactly
//     one cycle per completed frame and cannot be back-pressured. in_id,
//     in_ext, in_dlc, in_data and in_crc_ok are only meaningful while
//     in_valid=1.
//   - Output side is strict valid/ready. out_valid=1 means out_* hold the
//     oldest stored frame. A transfer happens on every rising edge where
//     out_valid=1 and out_ready=1. out_valid never depends on out_ready.
//     out_ready may be high while out_valid=0; that has no effect.
//   - While out_valid=0, all out_* fields are driven to zero.
interface can_rx_accept_fifo_if #(
  parameter int NUM_FILTERS = 4
);
  localparam int HIT_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

  // Decoder -> FIFO
  logic             in_valid;
  logic [28:0]      in_id;
  logic             in_ext;
  logic [3:0]       in_dlc;
  logic [63:0]      in_data;
  logic             in_crc_ok;

  // FIFO -> consumer
  logic             out_valid;
  logic             out_ready;
  logic [28:0]      out_id;
  logic             out_ext;
  logic [3:0]       out_dlc;
  logic [63:0]      out_data;
  logic [HIT_W-1:0] out_hit;

  // Producer and consumer side: drives frames in, takes frames out
  modport master (
    output in_valid, in_id, in_ext, in_dlc, in_data, in_crc_ok,
    output out_ready,
    input  out_valid, out_id, out_ext, out_dlc, out_data, out_hit
  );

  // FIFO side
  modport slave (
    input  in_valid, in_id, in_ext, in_dlc, in_data, in_crc_ok,
    input  out_ready,
    output out_valid, out_id, out_ext, out_dlc, out_data, out_hit
  );
endinterface

// File: rtl/can_rx_accept_fifo.sv
// CAN receive acceptance filter and frame FIFO.
// The block checks each decoded frame against NUM_FILTERS mask/match filters.
// A frame with a good CRC that hits at least one filter is sanitised and
// stored. The lowest-index hitting filter is stored with the frame. The FIFO
// is show-ahead and is drained by a valid/ready consumer. If an accepted frame
// arrives while the FIFO is full and no pop happens in the same cycle, the
// frame is lost and is counted in a saturating drop counter.
module can_rx_accept_fifo #(
  parameter int NUM_FILTERS = 4,
  parameter int DEPTH       = 8,
  parameter int CNT_W       = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  can_rx_accept_fifo_if.slave        bus,
  input  logic [29*NUM_FILTERS-1:0]  flt_id,
  input  logic [29*NUM_FILTERS-1:0]  flt_mask,
  input  logic [NUM_FILTERS-1:0]     flt_ext,
  input  logic [NUM_FILTERS-1:0]     flt_en,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       drop,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int HIT_W   = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int COUNT_W = $clog2(DEPTH+1);

  // Standard frames compare only the 11-bit identifier.
  localparam logic [28:0] STD_ID_BITS = 29'h0000_07FF;
  localparam logic [28:0] EXT_ID_BITS = 29'h1FFF_FFFF;

  typedef struct packed {
    logic [28:0]      id;
    logic             ext;
    logic [3:0]       dlc;
    logic [63:0]      data;
    logic [HIT_W-1:0] hit;
  } entry_t;

  // ------------------------------------------------------------------
  // Acceptance filters
  // ------------------------------------------------------------------
  logic [NUM_FILTERS-1:0] hit_vec;
  logic [28:0]            id_cmp_bits;

  assign id_cmp_bits = bus.in_ext ? EXT_ID_BITS : STD_ID_BITS;

  for (genvar k = 0; k < NUM_FILTERS; k++) begin : g_flt
    logic [28:0] cmp_mask;
    logic [28:0] id_diff;

    assign cmp_mask   = flt_mask[29*k +: 29] & id_cmp_bits;
    assign id_diff    = bus.in_id ^ flt_id[29*k +: 29];
    assign hit_vec[k] = flt_en[k] && (flt_ext[k] == bus.in_ext) &&
                        ((id_diff & cmp_mask) == '0);
  end

  logic             hit_any;
  logic [HIT_W-1:0] hit_idx;

  // Priority encode: the lowest-index hitting filter wins
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int k = NUM_FILTERS - 1; k >= 0; k--) begin
      if (hit_vec[k]) begin
        hit_any = 1'b1;
        hit_idx = HIT_W'(k);
      end
    end
  end

  // ------------------------------------------------------------------
  // Write-side sanitising
  // ------------------------------------------------------------------
  logic [3:0]  wr_dlc;
  logic [63:0] wr_data;
  entry_t      wr_entry;

  // Clamp dlc to 8 and zero the payload bytes past the stored length
  always_comb begin
    wr_dlc  = (bus.in_dlc > 4'd8) ? 4'd8 : bus.in_dlc;
    wr_data = '0;
    for (int b = 0; b < 8; b++) begin
      if (b < int'(wr_dlc)) begin
        wr_data[63-8*b -: 8] = bus.in_data[63-8*b -: 8];
      end
    end
    wr_entry.id   = bus.in_id;
    wr_entry.ext  = bus.in_ext;
    wr_entry.dlc  = wr_dlc;
    wr_entry.data = wr_data;
    wr_entry.hit  = hit_idx;
  end

  // ------------------------------------------------------------------
  // FIFO control
  // ------------------------------------------------------------------
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               drop_q, drop_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic   accept;
  logic   full;
  logic   head_valid;
  logic   pop;
  logic   push;
  logic   write_en;
  entry_t mem_q [DEPTH];
  entry_t head;

  assign accept     = bus.in_valid & bus.in_crc_ok & hit_any;
  assign full       = (count_q == COUNT_W'(DEPTH));
  assign head_valid = (count_q != '0);
  assign pop        = head_valid & bus.out_ready;
  // When the FIFO is full, a same-cycle pop frees the slot that the push uses.
  assign push       = accept & (~full | pop);

  // Next-state for pointers, occupancy and drop accounting; flush wins
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_d     = 1'b0;
    drop_cnt_d = drop_cnt_q;
    write_en   = 1'b0;
    if (flush) begin
      // A frame that arrives in the same cycle as a flush is discarded,
      // not dropped. drop_cnt keeps its value.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        write_en = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + COUNT_W'(1);
        2'b01:   count_d = count_q - COUNT_W'(1);
        default: count_d = count_q;
      endcase
      drop_d = accept & full & ~pop;
      if (drop_d && (drop_cnt_q != {CNT_W{1'b1}})) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
    end
  end

  // Control state register, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Frame storage. It has no reset because an empty FIFO hides every entry.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign head = mem_q[rd_ptr_q];

  // Show-ahead head. All fields are zero while the FIFO is empty.
  always_comb begin
    bus.out_valid = head_valid;
    bus.out_id    = '0;
    bus.out_ext   = 1'b0;
    bus.out_dlc   = '0;
    bus.out_data  = '0;
    bus.out_hit   = '0;
    if (head_valid) begin
      bus.out_id   = head.id;
      bus.out_ext  = head.ext;
      bus.out_dlc  = head.dlc;
      bus.out_data = head.data;
      bus.out_hit  = head.hit;
    end
  end

  assign count    = count_q;
  assign drop     = drop_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_can_rx_accept_fifo.sv
// Bench for can_rx_accept_fifo.
// The stimulus driver issues frames, predicts the FIFO contents and pushes
// the expected entries into exp_q. The monitor pops exp_q and compares on
// every output handshake.
module tb_can_rx_accept_fifo;

  localparam int NF    = 4;
  localparam int DEPTH = 8;
  localparam int CNT_W = 8;
  localparam int HIT_W = 2;
  localparam int W     = 29 + 1 + 4 + 64 + HIT_W;

  logic                 clk;
  logic                 rst;
  logic                 flush;
  logic [29*NF-1:0]     flt_id;
  logic [29*NF-1:0]     flt_mask;
  logic [NF-1:0]        flt_ext;
  logic [NF-1:0]        flt_en;
  logic [3:0]           count;
  logic                 drop;
  logic [CNT_W-1:0]     drop_cnt;

  can_rx_accept_fifo_if #(.NUM_FILTERS(NF)) bus ();

  can_rx_accept_fifo #(.NUM_FILTERS(NF), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .bus      (bus),
    .flt_id   (flt_id),
    .flt_mask (flt_mask),
    .flt_ext  (flt_ext),
    .flt_en   (flt_en),
    .count    (count),
    .drop     (drop),
    .drop_cnt (drop_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           n_checks;
  int           n_fail;
  int           exp_drops;
  logic         exp_drop_now;
  int           drop_seen;

  logic [28:0]  f_id   [NF];
  logic [28:0]  f_mask [NF];
  logic         f_ext  [NF];
  logic         f_en   [NF];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_cfg();
    for (int k = 0; k < NF; k++) begin
      flt_id[29*k +: 29]   = f_id[k];
      flt_mask[29*k +: 29] = f_mask[k];
      flt_ext[k]           = f_ext[k];
      flt_en[k]            = f_en[k];
    end
  endtask

  // Reference: the rules stated for acceptance and storage, written as plain arithmetic
  function automatic void ref_frame(input logic v, input logic [28:0] id, input logic ext,
                                    input logic [3:0] dlc, input logic [63:0] data,
                                    input logic crc, output logic acc, output logic [W-1:0] ent);
    int          hit_k;
    int          dlc_s;
    logic [28:0] cmp;
    logic [63:0] ones;
    logic [63:0] keep;
    acc   = 1'b0;
    hit_k = 0;
    cmp   = ext ? 29'h1FFFFFFF : 29'h7FF;
    if (v && crc) begin
      for (int k = 0; k < NF; k++) begin
        if (!acc && f_en[k] && (f_ext[k] == ext) && (((id ^ f_id[k]) & f_mask[k] & cmp) == 29'h0)) begin
          acc   = 1'b1;
          hit_k = k;
        end
      end
    end
    dlc_s = (int'(dlc) > 8) ? 8 : int'(dlc);
    ones  = 64'hFFFF_FFFF_FFFF_FFFF;
    keep  = ones << (8 * (8 - dlc_s));
    ent   = {id, ext, 4'(dlc_s), data & keep, 2'(hit_k)};
  endfunction

  // ---------------- driver ----------------
  // Runs one clock cycle. Call it at posedge+1. It returns at posedge+1 of
  // the next cycle.
  task automatic step(input logic v, input logic [28:0] id, input logic ext, input logic [3:0] dlc,
                      input logic [63:0] data, input logic crc, input logic rdy, input logic fl);
    logic         acc;
    logic [W-1:0] ent;
    logic         pop_now;
    int           sz;
    sz = exp_q.size();
    check("count", count, sz);
    check("out_valid", bus.out_valid, (sz != 0));
    check("drop", drop, exp_drop_now);
    check("drop_cnt", drop_cnt, exp_drops);
    if (fl) rdy = 1'b0;
    bus.in_valid  = v;
    bus.in_id     = id;
    bus.in_ext    = ext;
    bus.in_dlc    = dlc;
    bus.in_data   = data;
    bus.in_crc_ok = crc;
    bus.out_ready = rdy;
    flush         = fl;
    ref_frame(v, id, ext, dlc, data, crc, acc, ent);
    pop_now      = rdy && (sz != 0);
    exp_drop_now = 1'b0;
    if (fl) begin
      exp_q.delete();
    end else if (acc) begin
      if (sz - int'(pop_now) < DEPTH) begin
        exp_q.push_back(ent);
      end else begin
        exp_drop_now = 1'b1;
        if (exp_drops < (1 << CNT_W) - 1) exp_drops++;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.in_crc_ok = 1'b0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 29'h0, 1'b0, 4'h0, 64'h0, 1'b0, rdy, 1'b0);
  endtask

  task automatic push_std(input logic [28:0] id, input logic [3:0] dlc, input logic [63:0] data,
                          input logic rdy);
    step(1'b1, id, 1'b0, dlc, data, 1'b1, rdy, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * DEPTH; i++) begin
      if (exp_q.size() == 0) break;
      idle(1'b1);
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  // ---------------- monitor ----------------
  // Compares the FIFO head on every handshake. An empty FIFO must drive
  // zero fields.
  always @(negedge clk) begin
    logic [W-1:0] got;
    if (!rst) begin
      got = {bus.out_id, bus.out_ext, bus.out_dlc, bus.out_data, bus.out_hit};
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected: got %0h expected no output", got);
        end else begin
          check("pop_frame", got, exp_q.pop_front());
        end
      end
      if (!bus.out_valid) check("idle_zero", got, 0);
      if (drop) drop_seen++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    n_checks     = 0;
    n_fail       = 0;
    exp_drops    = 0;
    exp_drop_now = 1'b0;
    drop_seen    = 0;
    rst          = 1'b1;
    flush        = 1'b0;
    bus.in_valid = 1'b0; bus.in_id = '0; bus.in_ext = 1'b0; bus.in_dlc = '0;
    bus.in_data  = '0;   bus.in_crc_ok = 1'b0; bus.out_ready = 1'b0;
    for (int k = 0; k < NF; k++) begin
      f_id[k] = '0; f_mask[k] = '0; f_ext[k] = 1'b0; f_en[k] = 1'b0;
    end
    f_id[0] = 29'h195; f_mask[0] = 29'h7FF; f_en[0] = 1'b1;
    apply_cfg();
    #1;
    check("rst_count", count, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Standard frame accepted by filter 0. Output appears one cycle later.
    push_std(29'h195, 4'd8, 64'hA1A2A3A4A5A6A7A8, 1'b0);
    check("lat1_valid", bus.out_valid, 1);
    check("lat1_hit", bus.out_hit, 0);
    check("lat1_id", bus.out_id, 29'h195);
    drain();
    push_std(29'h196, 4'd8, 64'h1, 1'b0);      // no filter hit
    check("nohit_count", count, 0);

    // Extended frame: filters 1 and 3 both match, so the lower index wins
    f_id[1] = 29'h1ABCDE0; f_mask[1] = 29'h1FFFFFFF; f_ext[1] = 1'b1; f_en[1] = 1'b1;
    f_id[3] = 29'h1ABCDE0; f_mask[3] = 29'h1FFFFFFF; f_ext[3] = 1'b1; f_en[3] = 1'b1;
    apply_cfg();
    step(1'b1, 29'h1ABCDE0, 1'b1, 4'd4, 64'hDEADBEEF_00000000, 1'b1, 1'b0, 1'b0);
    check("ext_hit", bus.out_hit, 1);
    drain();
    step(1'b1, 29'h1ABCDE0, 1'b1, 4'd4, 64'hDEADBEEF_00000000, 1'b0, 1'b0, 1'b0);
    check("badcrc_count", count, 0);

    // Ten back-to-back frames into a depth-8 FIFO with no reads
    d0 = drop_seen;
    for (int i = 0; i < 10; i++) push_std(29'h195, 4'd8, 64'(i + 1) * 64'h0101_0101_0101_0101, 1'b0);
    idle(1'b0);
    check("full_count", count, 8);
    check("drop_pulses", drop_seen - d0, 2);
    check("drop_cnt_2", drop_cnt, 2);
    drain();

    // When full, a push and a pop in the same cycle leave count at DEPTH
    for (int i = 0; i < DEPTH; i++) push_std(29'h195, 4'd3, {32'(i), 32'h0}, 1'b0);
    push_std(29'h195, 4'd8, 64'hFEED_FACE_CAFE_BEEF, 1'b1);
    check("fullpp_count", count, 8);
    check("fullpp_drop", drop, 0);
    drain();

    // dlc clamping and payload truncation
    push_std(29'h195, 4'd12, 64'h1122334455667788, 1'b0);
    check("clamp_dlc", bus.out_dlc, 8);
    check("clamp_data", bus.out_data, 64'h1122334455667788);
    drain();
    push_std(29'h195, 4'd2, 64'h1122334455667788, 1'b0);
    check("trunc_data", bus.out_data, 64'h1122000000000000);
    drain();

    // A flush wins over a same-cycle push
    for (int i = 0; i < 3; i++) push_std(29'h195, 4'd1, 64'hFF00_0000_0000_0000, 1'b0);
    step(1'b1, 29'h195, 1'b0, 4'd1, 64'h0, 1'b1, 1'b0, 1'b1);
    check("flush_count", count, 0);
    check("flush_valid", bus.out_valid, 0);

    // Randomised traffic against the reference model
    for (int k = 0; k < NF; k++) begin
      f_en[k]   = ($urandom_range(0, 3) != 0);
      f_ext[k]  = $urandom_range(0, 1) != 0;
      f_id[k]   = f_ext[k] ? 29'($urandom) : 29'($urandom_range(0, 2047));
      f_mask[k] = 29'($urandom) | 29'($urandom);
    end
    apply_cfg();
    for (int c = 0; c < 1500; c++) begin
      logic [28:0] id;
      logic        ext;
      int          k;
      k = $urandom_range(0, NF - 1);
      if ($urandom_range(0, 9) < 6) begin
        ext = f_ext[k];
        id  = (f_id[k] & f_mask[k]) | (29'($urandom) & ~f_mask[k]);
      end else begin
        ext = $urandom_range(0, 1) != 0;
        id  = 29'($urandom);
      end
      if (!ext) id = id & 29'h7FF;
      step($urandom_range(0, 9) < 7, id, ext, 4'($urandom_range(0, 15)),
           {$urandom, $urandom}, $urandom_range(0, 9) != 0,
           $urandom_range(0, 9) < 4, $urandom_range(0, 49) == 0);
    end
    drain();

    // drop_cnt saturates
    f_id[0] = 29'h195; f_mask[0] = 29'h7FF; f_ext[0] = 1'b0; f_en[0] = 1'b1;
    apply_cfg();
    for (int i = 0; i < DEPTH + 270; i++) push_std(29'h195, 4'd8, {$urandom, $urandom}, 1'b0);
    idle(1'b0);
    check("drop_sat", drop_cnt, 255);
    step(1'b0, 29'h0, 1'b0, 4'h0, 64'h0, 1'b0, 1'b0, 1'b1);
    check("flush_keeps_drop_cnt", drop_cnt, 255);

    // Reset asserted in the middle of traffic
    for (int i = 0; i < 4; i++) push_std(29'h195, 4'd8, {$urandom, $urandom}, 1'b0);
    bus.in_valid = 1'b1; bus.in_id = 29'h195; bus.in_crc_ok = 1'b1; bus.in_dlc = 4'd8;
    rst = 1'b1;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_fields", {bus.out_id, bus.out_ext, bus.out_dlc, bus.out_data, bus.out_hit}, 0);
    check("mid_rst_drop", drop, 0);
    check("mid_rst_drop_cnt", drop_cnt, 0);
    exp_q.delete();
    exp_drops    = 0;
    exp_drop_now = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_crc_ok = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_std(29'h195, 4'd5, 64'h0102030405060708, 1'b0);
    check("post_rst_data", bus.out_data, 64'h0102030405000000);
    drain();
    idle(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/can_rx_accept_fifo.md
CAN_RX_ACCEPT_FIFO -- requirements
Module: can_rx_accept_fifo

Interface
REQ-001 SHALL have parameter NUM_FILTERS, default 4: number of acceptance filters, range 1..16.
REQ-002 SHALL have parameter DEPTH, default 8: number of FIFO frame entries, a power of two, range 2..64.
REQ-003 SHALL have parameter CNT_W, default 8: width of the saturating drop counter.
REQ-004 clk  in  1  clock; all logic is rising-edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 flush  in  1  synchronous FIFO clear.
REQ-007 in_valid  in  1  one-cycle strobe marking a completed decoded frame.
REQ-008 in_id  in  29  identifier; standard frames use [10:0] only.
REQ-009 in_ext  in  1  1 = extended (29-bit) frame.
REQ-010 in_dlc  in  4  data length code.
REQ-011 in_data  in  64  payload; byte 0 is in [63:56].
REQ-012 in_crc_ok  in  1  received CRC checked good.
REQ-013 flt_id  in  29*NUM_FILTERS  filter k match value, held in slice [29k+28:29k].
REQ-014 flt_mask  in  29*NUM_FILTERS  filter k mask; 1 = bit compared.
REQ-015 flt_ext  in  NUM_FILTERS  frame type required by filter k.
REQ-016 flt_en  in  NUM_FILTERS  filter k enable.
REQ-017 out_valid  out  1  FIFO head is present.
REQ-018 out_ready  in  1  consumer accepts the head.
REQ-019 out_id, out_ext, out_dlc, out_data  out  29/1/4/64  head frame fields.
REQ-020 out_hit  out  max(1,$clog2(NUM_FILTERS))  index of the filter that accepted the head frame.
REQ-021 count  out  $clog2(DEPTH+1)  number of occupied entries.
REQ-022 drop  out  1  one-cycle pulse when an accepted frame is lost because the FIFO is full.
REQ-023 drop_cnt  out  CNT_W  saturating count of drop pulses.

Function
REQ-024 Filter k SHALL hit when flt_en[k]=1, flt_ext[k]=in_ext, and ((in_id^flt_id_k)&flt_mask_k)=0; for standard frames, bits [28:11] SHALL be excluded from the comparison.
REQ-025 A frame SHALL be accepted when in_valid=1, in_crc_ok=1 and at least one filter hits; the lowest-index hitting filter SHALL determine out_hit.
REQ-026 Frames that fail CRC, or that hit no filter, SHALL be discarded silently with no state change.
REQ-027 An accepted frame SHALL be written at the rising edge ending the in_valid cycle; when the FIFO was empty, out_valid SHALL rise in the next cycle (latency 1).
REQ-028 On write, in_dlc values greater than 8 SHALL be stored as 8, and payload bytes at index >= stored dlc SHALL be stored as zero.
REQ-029 Output SHALL be show-ahead: out_* present the oldest entry whenever out_valid=1.
REQ-030 A pop SHALL occur on a cycle with out_valid=1 and out_ready=1; out_ready while empty SHALL have no effect.
REQ-031 out_id, out_ext, out_dlc, out_data and out_hit SHALL be driven to zero while out_valid=0.
REQ-032 Push and pop in the same cycle SHALL both take effect and leave count unchanged, including when the FIFO is full.
REQ-033 A push while count=DEPTH with no simultaneous pop SHALL be dropped: drop pulses for one cycle and drop_cnt increments, saturating at 2^CNT_W-1.
REQ-034 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH.
REQ-035 in_valid on consecutive cycles SHALL be supported, with every accepted frame stored.
REQ-036 flush SHALL empty the FIFO at the next edge and take priority over a same-cycle push and pop; drop_cnt SHALL be unaffected by flush.

Reset
REQ-037 While rst=1: pointers, count and drop_cnt SHALL be 0; out_valid and drop SHALL be 0; all out_* fields SHALL be 0.
REQ-038 Deassertion of rst SHALL take effect at the next clk edge; a frame in progress at reset SHALL be lost.

Verification
REQ-039 Filter 0 set to id=0x195 std, mask=0x7FF; push std id 0x195, crc_ok=1 -> out_valid=1 the next cycle, out_hit=0, out_id=0x195.
REQ-040 Filters 1 and 3 both match ext id 0x1ABCDE0; push -> out_hit=1; the same frame with crc_ok=0 -> count stays 0.
REQ-041 DEPTH=8, out_ready=0, push 10 accepted frames back-to-back -> count=8, exactly 2 drop pulses, drop_cnt=2; drain -> the first 8 frames come out in order.
REQ-042 FIFO full, push plus out_ready=1 in the same cycle -> count stays 8, no drop, the new frame appears last.
REQ-043 dlc=12 with data 0x1122334455667788 -> stored dlc=8, data unchanged; dlc=2 -> out_data=0x1122000000000000.
REQ-044 3 entries queued, then flush together with a push -> count=0 and out_valid=0 the next cycle; assert rst mid-stream -> all outputs 0 immediately.
